fd_bank: RTL and testbench

Parametrised multi-channel D-type capture register for the Slipstream core, the successor to the single-bit master-clock-sampled flip-flop. Each of `CHANNELS` lanes holds a `WIDTH`-bit value and captures its data on an edge (or level) of its own slow gate signal. All lanes sample that gate in the `MasterClock` domain. Used where chip-internal strobes (register writes, video/DMA latches) must be captured without creating extra clock domains.

---
 rtl/fd_pkg.sv | 20 ++
 rtl/fd_lane.sv | 96 +++++++++
 rtl/fd_bank.sv | 60 ++++++
 tb/tb_fd_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// ----------------------------------------------------------------------------
// fd_pkg
// Shared definitions for the fd_bank capture register family.
//   edge_mode_t : per-lane capture mode (RISE/FALL/BOTH/TRANSP)
//   lane_lsb()  : bit offset of a lane inside a packed multi-lane bus
// ----------------------------------------------------------------------------
package fd_pkg;

    typedef enum logic [1:0] {
        RISE   = 2'd0,
        FALL   = 2'd1,
        BOTH   = 2'd2,
        TRANSP = 2'd3
    } edge_mode_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fd_lane.sv
// ----------------------------------------------------------------------------
// fd_lane
// One capture channel: optional gate synchroniser, previous-gate register,
// capture decode and the q / pulse registers. Everything runs on MasterClock.
// Ports:
//   i_clk      : MasterClock
//   i_rst      : asynchronous active-high reset
//   i_gate     : slow capture strobe for this lane
//   i_mode     : edge_mode_t encoding, unregistered
//   i_d        : data to capture
//   o_q        : captured value
//   o_captured : one-cycle pulse, lane loaded i_d
//   o_changed  : one-cycle pulse, loaded value differed from previous o_q
// ----------------------------------------------------------------------------
module fd_lane
    import fd_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gate,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_captured,
    output logic             o_changed
);

    logic             w_gs;
    logic             w_hit;
    edge_mode_t       w_mode;
    logic             r_gold;
    logic [WIDTH-1:0] r_q;
    logic             r_captured;
    logic             r_changed;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_gs = i_gate;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            // Shift form keeps SYNC_STAGES=1 legal (no negative slice).
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= (r_sync << 1) | SYNC_STAGES'(i_gate);
                end
            end
            assign w_gs = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_mode = edge_mode_t'(i_mode);

    always_comb begin
        w_hit = 1'b0;
        case (w_mode)
            RISE:    w_hit = !r_gold && w_gs;
            FALL:    w_hit = r_gold && !w_gs;
            BOTH:    w_hit = r_gold != w_gs;
            TRANSP:  w_hit = w_gs;
            default: w_hit = 1'b0;
        endcase
    end

    // r_gold tracks the gate every cycle independent of mode, so switching
    // mode never manufactures an edge. Reset to 0 makes a gate that is
    // already high at release count as a rising edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gold     <= 1'b0;
            r_q        <= RESET_VALUE;
            r_captured <= 1'b0;
            r_changed  <= 1'b0;
        end else begin
            r_gold <= w_gs;
            if (w_hit) begin
                r_q        <= i_d;
                r_captured <= 1'b1;
                r_changed  <= (i_d != r_q);
            end else begin
                r_captured <= 1'b0;
                r_changed  <= 1'b0;
            end
        end
    end

    assign o_q        = r_q;
    assign o_captured = r_captured;
    assign o_changed  = r_changed;

endmodule

// File: rtl/fd_bank.sv
// ----------------------------------------------------------------------------
// fd_bank
// Multi-channel D-type capture register. Each lane captures its d slice on
// an edge (or level) of its own gate, sampled in the MasterClock domain.
// Ports:
//   MasterClock : sole clock, rising edge
//   reset       : asynchronous active-high reset
//   gate        : per-lane capture strobe
//   mode        : per-lane edge_mode_t, lane i at bits [2*i +: 2]
//   d           : per-lane data, lane i at bits [i*WIDTH +: WIDTH]
//   q           : captured values
//   qL          : bitwise complement of q
//   captured    : per-lane one-cycle capture pulse
//   changed     : per-lane one-cycle pulse when the captured value differed
// ----------------------------------------------------------------------------
module fd_bank
    import fd_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      MasterClock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       gate,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] qL,
    output logic [CHANNELS-1:0]       captured,
    output logic [CHANNELS-1:0]       changed
);

    logic [CHANNELS*WIDTH-1:0] w_q;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
            localparam int LSB = lane_lsb(i, WIDTH);
            fd_lane #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VALUE (RESET_VALUE)
            ) u_lane (
                .i_clk      (MasterClock),
                .i_rst      (reset),
                .i_gate     (gate[i]),
                .i_mode     (mode[2*i +: 2]),
                .i_d        (d[LSB +: WIDTH]),
                .o_q        (w_q[LSB +: WIDTH]),
                .o_captured (captured[i]),
                .o_changed  (changed[i])
            );
        end
    endgenerate

    assign q  = w_q;
    assign qL = ~w_q;

endmodule

// File: tb/tb_fd_bank.sv
// ----------------------------------------------------------------------------
// tb_fd_bank
// Two fd_bank instances (direct sampling and two-stage synchroniser) share
// the same stimulus and are compared every cycle against a queue-based
// reference model, plus directed checks of the headline behaviours.
// ----------------------------------------------------------------------------
module tb_fd_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gate;
    logic [7:0]  mode;
    logic [31:0] d;

    logic [31:0] q0, qL0, q2, qL2;
    logic [3:0]  cap0, chg0, cap2, chg2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fd_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(0), .RESET_VALUE(8'hA5)) u_dut0 (
        .MasterClock (clk),
        .reset       (rst),
        .gate        (gate),
        .mode        (mode),
        .d           (d),
        .q           (q0),
        .qL          (qL0),
        .captured    (cap0),
        .changed     (chg0)
    );

    fd_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .RESET_VALUE(8'hA5)) u_dut2 (
        .MasterClock (clk),
        .reset       (rst),
        .gate        (gate),
        .mode        (mode),
        .d           (d),
        .q           (q2),
        .qL          (qL2),
        .captured    (cap2),
        .changed     (chg2)
    );

    // Reference model: history of gate vectors seen at each edge since reset.
    // The gate a lane "sees" at edge n is the one presented S edges earlier.
    logic [3:0] gq[$];
    logic [7:0] mq   [2][4];
    logic [3:0] mcap [2];
    logic [3:0] mchg [2];
    int         sdel [2] = '{0, 2};

    function automatic logic gs_of(input int k, input int l, input int back);
        int idx;
        idx = gq.size() - 1 - back - sdel[k];
        if (idx < 0) return 1'b0;
        return gq[idx][l];
    endfunction

    function automatic logic [31:0] mpack(input int k);
        return {mq[k][3], mq[k][2], mq[k][1], mq[k][0]};
    endfunction

    task automatic model_reset();
        gq.delete();
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 4; l++) mq[k][l] = 8'hA5;
            mcap[k] = 4'h0;
            mchg[k] = 4'h0;
        end
    endtask

    task automatic model_edge();
        logic       gs, gold, hit;
        logic [1:0] m;
        logic [7:0] dl;
        if (rst) return;
        gq.push_back(gate);
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 4; l++) begin
                gs   = gs_of(k, l, 0);
                gold = gs_of(k, l, 1);
                m    = mode[2*l +: 2];
                dl   = d[8*l +: 8];
                case (m)
                    2'd0:    hit = !gold && gs;
                    2'd1:    hit = gold && !gs;
                    2'd2:    hit = gold != gs;
                    default: hit = gs;
                endcase
                if (hit) begin
                    mchg[k][l] = (dl != mq[k][l]);
                    mq[k][l]   = dl;
                    mcap[k][l] = 1'b1;
                end else begin
                    mchg[k][l] = 1'b0;
                    mcap[k][l] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".q0"},    q0,             mpack(0));
        chk({tag, ".qL0"},   qL0,            ~mpack(0));
        chk({tag, ".cap0"},  {28'h0, cap0},  {28'h0, mcap[0]});
        chk({tag, ".chg0"},  {28'h0, chg0},  {28'h0, mchg[0]});
        chk({tag, ".q2"},    q2,             mpack(1));
        chk({tag, ".qL2"},   qL2,            ~mpack(1));
        chk({tag, ".cap2"},  {28'h0, cap2},  {28'h0, mcap[1]});
        chk({tag, ".chg2"},  {28'h0, chg2},  {28'h0, mchg[1]});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst  = 1'b1;
        gate = 4'h0;
        mode = 8'h00;
        d    = 32'h0;
        #1;
        model_reset();
        compare_all("rst");
        chk("rst_q0",  q0,  32'hA5A5A5A5);
        chk("rst_qL0", qL0, 32'h5A5A5A5A);
        step("rst_hold");
        step("rst_hold");

        // Release with lane 0 gate already high: counts as a rising edge.
        gate = 4'b0001;
        d    = 32'h00000077;
        rst  = 1'b0;
        step("rel");
        chk("rel_q0",   {24'h0, q0[7:0]}, 32'h77);
        chk("rel_cap0", {28'h0, cap0},    32'h1);
        chk("rel_cap2", {28'h0, cap2},    32'h0);
        gate = 4'b0000;
        repeat (3) step("rel_settle");

        // RISE, then repeat with identical data.
        d    = 32'h0000003C;
        gate = 4'b0001;
        step("rise");
        chk("rise_q0",   {24'h0, q0[7:0]}, 32'h3C);
        chk("rise_cap0", {28'h0, cap0},    32'h1);
        chk("rise_chg0", {28'h0, chg0},    32'h1);
        step("rise_hold");
        chk("rise_hold_cap0", {28'h0, cap0}, 32'h0);
        gate = 4'b0000;
        repeat (3) step("rise_low");
        gate = 4'b0001;
        step("rise_same");
        chk("rise_same_cap0", {28'h0, cap0}, 32'h1);
        chk("rise_same_chg0", {28'h0, chg0}, 32'h0);
        gate = 4'b0000;
        repeat (4) step("rise_settle");

        // FALL: capture only on the 1->0 transition.
        mode = 8'h01;
        gate = 4'b0001;
        d = 32'h11; step("fall_h1");
        d = 32'h22; step("fall_h2");
        d = 32'h33; step("fall_h3");
        chk("fall_nocap0", {28'h0, cap0}, 32'h0);
        gate = 4'b0000;
        step("fall_edge");
        chk("fall_q0",   {24'h0, q0[7:0]}, 32'h33);
        chk("fall_cap0", {28'h0, cap0},    32'h1);
        repeat (3) step("fall_settle");

        // BOTH: capture at each transition.
        mode = 8'h02;
        gate = 4'b0001;
        d = 32'h11; step("both_h1");
        chk("both_rise_q0", {24'h0, q0[7:0]}, 32'h11);
        d = 32'h22; step("both_h2");
        d = 32'h33; step("both_h3");
        gate = 4'b0000;
        step("both_fall");
        chk("both_fall_q0",   {24'h0, q0[7:0]}, 32'h33);
        chk("both_fall_cap0", {28'h0, cap0},    32'h1);
        repeat (3) step("both_settle");

        // TRANSP: follow while high, hold while low.
        mode = 8'h03;
        gate = 4'b0001;
        d = 32'h01; step("tr1");
        chk("tr1_chg0", {28'h0, chg0}, 32'h1);
        d = 32'h02; step("tr2");
        d = 32'h02; step("tr3");
        chk("tr3_cap0", {28'h0, cap0}, 32'h1);
        chk("tr3_chg0", {28'h0, chg0}, 32'h0);
        gate = 4'b0000;
        d = 32'h09; step("tr_low");
        chk("tr_low_q0", {24'h0, q0[7:0]}, 32'h02);
        repeat (3) step("tr_settle");

        // Simultaneous rises on lanes 0 and 3; synchronised copy lags by 2.
        mode = 8'h00;
        gate = 4'b1001;
        d    = 32'hAA000055;
        step("sync_e0");
        chk("sync_e0_cap0", {28'h0, cap0}, 32'h9);
        chk("sync_e0_cap2", {28'h0, cap2}, 32'h0);
        step("sync_e1");
        step("sync_e2");
        chk("sync_e2_cap2",  {28'h0, cap2},  32'h9);
        chk("sync_e2_q2mid", {16'h0, q2[23:8]}, 32'hA5A5);

        // Mode switch RISE->FALL with gate held high: wait for the fall.
        mode = 8'h55;
        repeat (3) step("msw_hold");
        chk("msw_hold_cap0", {28'h0, cap0}, 32'h0);
        gate = 4'b0000;
        step("msw_fall");
        chk("msw_fall_cap0", {28'h0, cap0}, 32'h9);
        repeat (3) step("msw_settle");

        // Mid-cycle asynchronous reset, then release with all gates high.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst");
        chk("arst_q0",  q0,  32'hA5A5A5A5);
        chk("arst_qL2", qL2, 32'h5A5A5A5A);
        step("arst_hold");
        mode = 8'h00;
        gate = 4'hF;
        d    = 32'h12345678;
        rst  = 1'b0;
        step("arst_rel");
        chk("arst_rel_cap0", {28'h0, cap0}, 32'hF);
        chk("arst_rel_q0",   q0,            32'h12345678);

        // Randomised traffic with occasional short reset pulses.
        for (int n = 0; n < 400; n++) begin
            gate = 4'($urandom);
            mode = 8'($urandom);
            d    = ($urandom_range(0, 3) == 0) ? d : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare_all("rnd_rst");
                #1;
                rst = 1'b0;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
